bp_nonsynth_bedrock_hs_checker: RTL and testbench

Non-synthesizable, cycle-accurate checker for ready-and-valid BedRock channels (LCE req/cmd/resp, CCE mem cmd/resp), bound beside the tile and memory-side interfaces in testbenches. It generalises our elaboration-time width and parameter checks to runtime protocol checking across a configurable number of channels. Per channel it checks:
- valid stability
- payload stability while stalled
- a stall watchdog

It also counts accepted transactions and prints a summary. It never drives DUT signals.

---
 rtl/bp_nonsynth_bedrock_hs_checker_pkg.sv | 26 ++
 rtl/bp_nonsynth_hs_chan_checker.sv | 112 +++++++++++
 rtl/bp_nonsynth_bedrock_hs_checker.sv | 63 ++++++
 tb/tb_bp_nonsynth_bedrock_hs_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bp_nonsynth_bedrock_hs_checker_pkg.sv
// Shared types and constants for the BedRock ready/valid handshake checker.
package bp_nonsynth_bedrock_hs_checker_pkg;

  localparam int unsigned bp_hs_count_width_lp = 32;

  typedef enum logic {
    e_idle,
    e_pend
  } bp_hs_chk_state_e;

  typedef enum logic [1:0] {
    e_viol_drop,
    e_viol_data,
    e_viol_timeout
  } bp_hs_viol_e;

  function automatic string viol_name(bp_hs_viol_e viol);
    case (viol)
      e_viol_drop:    return "valid-drop";
      e_viol_data:    return "payload-change";
      e_viol_timeout: return "stall-timeout";
      default:        return "unknown";
    endcase
  endfunction

endpackage

// File: rtl/bp_nonsynth_hs_chan_checker.sv
// One channel's handshake monitor: idle/pend FSM, payload capture, stall watchdog,
// accepted-transaction count and sticky violation flags.
module bp_nonsynth_hs_chan_checker
  import bp_nonsynth_bedrock_hs_checker_pkg::*;
#(
  parameter int unsigned chan_idx_p       = 0,
  parameter int unsigned data_width_p     = 128,
  parameter int unsigned timeout_cycles_p = 1024,
  parameter bit          strict_p         = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            en_i,
  input  logic                            v_i,
  input  logic                            ready_and_i,
  input  logic [data_width_p-1:0]         data_i,
  output logic                            drop_err_o,
  output logic                            data_err_o,
  output logic                            timeout_o,
  output logic [bp_hs_count_width_lp-1:0] count_o
);

  localparam int unsigned WaitW = $clog2(timeout_cycles_p + 1);
  localparam logic [WaitW-1:0] TimeoutW = WaitW'(timeout_cycles_p);

  bp_hs_chk_state_e                state_q, state_d;
  logic [WaitW-1:0]                wait_q, wait_d;
  logic [data_width_p-1:0]         cap_q, cap_d;
  logic [bp_hs_count_width_lp-1:0] count_q, count_d;
  logic                            drop_q, data_q, to_q;
  logic                            drop_ev, data_ev, to_ev;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cap_d   = cap_q;
    count_d = count_q;
    drop_ev = 1'b0;
    data_ev = 1'b0;
    to_ev   = 1'b0;
    if (!en_i) begin
      state_d = e_idle;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        e_idle: begin
          if (v_i && ready_and_i) begin
            count_d = count_q + bp_hs_count_width_lp'(1);
          end else if (v_i) begin
            cap_d   = data_i;
            wait_d  = WaitW'(1);
            state_d = e_pend;
            to_ev   = (timeout_cycles_p == 1);
          end
        end
        e_pend: begin
          if (v_i) begin
            // First stalled beat stays the reference for the whole episode.
            data_ev = (data_i != cap_q);
            if (ready_and_i) begin
              count_d = count_q + bp_hs_count_width_lp'(1);
              wait_d  = '0;
              state_d = e_idle;
            end else if (wait_q != TimeoutW) begin
              wait_d = wait_q + WaitW'(1);
              to_ev  = (wait_d == TimeoutW);
            end
          end else begin
            drop_ev = 1'b1;
            wait_d  = '0;
            state_d = e_idle;
          end
        end
        default: state_d = e_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      wait_q  <= '0;
      cap_q   <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
      data_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cap_q   <= cap_d;
      count_q <= count_d;
      drop_q  <= drop_q | drop_ev;
      data_q  <= data_q | data_ev;
      to_q    <= to_q | to_ev;
      if (strict_p) begin
        if (drop_ev) $error("bp_hs_chk: channel %0d %s at %0t", chan_idx_p,
                            viol_name(e_viol_drop), $time);
        if (data_ev) $error("bp_hs_chk: channel %0d %s at %0t", chan_idx_p,
                            viol_name(e_viol_data), $time);
        if (to_ev)   $error("bp_hs_chk: channel %0d %s at %0t", chan_idx_p,
                            viol_name(e_viol_timeout), $time);
      end
    end
  end

  assign drop_err_o = drop_q;
  assign data_err_o = data_q;
  assign timeout_o  = to_q;
  assign count_o    = count_q;

endmodule

// File: rtl/bp_nonsynth_bedrock_hs_checker.sv
// Runtime ready/valid protocol checker across num_chan_p BedRock channels; observes only.
module bp_nonsynth_bedrock_hs_checker
  import bp_nonsynth_bedrock_hs_checker_pkg::*;
#(
  parameter int unsigned num_chan_p       = 5,
  parameter int unsigned data_width_p     = 128,
  parameter int unsigned timeout_cycles_p = 1024,
  parameter bit          strict_p         = 1'b1
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic                                       en_i,
  input  logic [num_chan_p-1:0]                      v_i,
  input  logic [num_chan_p-1:0]                      ready_and_i,
  input  logic [num_chan_p*data_width_p-1:0]         data_i,
  output logic [num_chan_p-1:0]                      drop_err_o,
  output logic [num_chan_p-1:0]                      data_err_o,
  output logic [num_chan_p-1:0]                      timeout_o,
  output logic [num_chan_p*bp_hs_count_width_lp-1:0] count_o,
  output logic                                       any_err_o
);

  if (num_chan_p < 1) begin : g_bad_num_chan
    $fatal(1, "bp_hs_chk: num_chan_p must be >= 1");
  end
  if (timeout_cycles_p < 1) begin : g_bad_timeout
    $fatal(1, "bp_hs_chk: timeout_cycles_p must be >= 1");
  end
  if (data_width_p < 1) begin : g_bad_width
    $fatal(1, "bp_hs_chk: data_width_p must be >= 1");
  end

  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    bp_nonsynth_hs_chan_checker #(
      .chan_idx_p      (c),
      .data_width_p    (data_width_p),
      .timeout_cycles_p(timeout_cycles_p),
      .strict_p        (strict_p)
    ) u_chan (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .en_i       (en_i),
      .v_i        (v_i[c]),
      .ready_and_i(ready_and_i[c]),
      .data_i     (data_i[c*data_width_p +: data_width_p]),
      .drop_err_o (drop_err_o[c]),
      .data_err_o (data_err_o[c]),
      .timeout_o  (timeout_o[c]),
      .count_o    (count_o[c*bp_hs_count_width_lp +: bp_hs_count_width_lp])
    );
  end

  assign any_err_o = (|drop_err_o) | (|data_err_o) | (|timeout_o);

  final begin
    for (int c = 0; c < num_chan_p; c++) begin
      $display("bp_hs_chk: channel %0d count=%0d drop_err=%0b data_err=%0b timeout=%0b", c,
               count_o[c*bp_hs_count_width_lp +: bp_hs_count_width_lp], drop_err_o[c],
               data_err_o[c], timeout_o[c]);
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_bedrock_hs_checker.sv
// Directed bench for the handshake checker: vector table plus hand-written multi-cycle sequences.
module tb_bp_nonsynth_bedrock_hs_checker;

  localparam int unsigned NC = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  typedef struct {
    logic                   rst;
    logic                   en;
    logic [NC-1:0]          v;
    logic [NC-1:0]          rdy;
    logic [NC-1:0][DW-1:0]  d;
    int                     ch;
    logic [31:0]            cnt;
    logic [NC-1:0]          e_drop;
    logic [NC-1:0]          e_data;
    logic [NC-1:0]          e_to;
  } vec_t;

  localparam logic [NC-1:0][DW-1:0] D0 = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0000};
  localparam logic [NC-1:0][DW-1:0] D1 = {16'h4444, 16'h3334, 16'h2222, 16'h1112, 16'h0000};

  logic                  clk;
  logic                  reset;
  logic                  en;
  logic [NC-1:0]         v;
  logic [NC-1:0]         rdy;
  logic [NC-1:0][DW-1:0] dat;
  logic [NC*DW-1:0]      data_flat;
  logic [NC-1:0]         drop_err;
  logic [NC-1:0]         data_err;
  logic [NC-1:0]         timeout;
  logic [NC*32-1:0]      count;
  logic                  any_err;

  int checks   = 0;
  int failures = 0;

  assign data_flat = dat;

  bp_nonsynth_bedrock_hs_checker #(
    .num_chan_p      (NC),
    .data_width_p    (DW),
    .timeout_cycles_p(TO),
    .strict_p        (1'b0)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (en),
    .v_i        (v),
    .ready_and_i(rdy),
    .data_i     (data_flat),
    .drop_err_o (drop_err),
    .data_err_o (data_err),
    .timeout_o  (timeout),
    .count_o    (count),
    .any_err_o  (any_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] cnt_of(input int c);
    return count[c*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [NC-1:0] ed, input logic [NC-1:0] edat,
                           input logic [NC-1:0] eto);
    chk({tag, " drop_err"}, 32'(drop_err), 32'(ed));
    chk({tag, " data_err"}, 32'(data_err), 32'(edat));
    chk({tag, " timeout"}, 32'(timeout), 32'(eto));
    chk({tag, " any_err"}, 32'(any_err), 32'((|ed) | (|edat) | (|eto)));
  endtask

  // Drive inputs, let one rising edge sample them, then look 1 time unit later.
  task automatic step(input logic r, input logic e, input logic [NC-1:0] vv,
                      input logic [NC-1:0] rr);
    reset = r;
    en    = e;
    v     = vv;
    rdy   = rr;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // Valid drop on ch2.
    vecs.push_back('{1'b1, 1'b1, 5'b00000, 5'b00000, '0, 2, 32'd0, 5'b0, 5'b0, 5'b0});
    vecs.push_back('{1'b0, 1'b1, 5'b00100, 5'b00000, '0, 2, 32'd0, 5'b0, 5'b0, 5'b0});
    vecs.push_back('{1'b0, 1'b1, 5'b00100, 5'b00000, '0, 2, 32'd0, 5'b0, 5'b0, 5'b0});
    vecs.push_back('{1'b0, 1'b1, 5'b00000, 5'b00000, '0, 2, 32'd0, 5'b00100, 5'b0, 5'b0});
    vecs.push_back('{1'b0, 1'b1, 5'b00100, 5'b00100, '0, 2, 32'd1, 5'b00100, 5'b0, 5'b0});
    // All channels stall together, then all violate/accept on the same edge.
    vecs.push_back('{1'b1, 1'b1, 5'b00000, 5'b00000, D0, 0, 32'd0, 5'b0, 5'b0, 5'b0});
    for (int i = 0; i < 7; i++) begin
      vecs.push_back('{1'b0, 1'b1, 5'b11111, 5'b00000, D0, 3, 32'd0, 5'b0, 5'b0, 5'b0});
    end
    vecs.push_back('{1'b0, 1'b1, 5'b11110, 5'b11000, D1, 3, 32'd1, 5'b00001, 5'b01010,
                     5'b00110});
    vecs.push_back('{1'b0, 1'b1, 5'b00000, 5'b00000, D1, 4, 32'd1, 5'b00111, 5'b01010,
                     5'b00110});

    reset = 1'b1;
    en    = 1'b1;
    v     = '0;
    rdy   = '0;
    dat   = '0;
    step(1'b1, 1'b1, 5'b0, 5'b0);
    step(1'b1, 1'b1, 5'b0, 5'b0);
    chk_flags("reset", 5'b0, 5'b0, 5'b0);
    for (int c = 0; c < NC; c++) chk($sformatf("reset count%0d", c), cnt_of(c), 32'd0);

    // Back-to-back handshakes on ch0.
    step(1'b0, 1'b1, 5'b0, 5'b0);
    for (int i = 0; i < 10; i++) begin
      dat[0] = 16'(16'h0100 + i);
      step(1'b0, 1'b1, 5'b00001, 5'b00001);
    end
    chk("b2b count0", cnt_of(0), 32'd10);
    chk_flags("b2b", 5'b0, 5'b0, 5'b0);

    // Stall 5 cycles then accept on ch1.
    step(1'b1, 1'b1, 5'b0, 5'b0);
    dat[1] = 16'hABCD;
    repeat (5) step(1'b0, 1'b1, 5'b00010, 5'b00000);
    chk_flags("stall5", 5'b0, 5'b0, 5'b0);
    step(1'b0, 1'b1, 5'b00010, 5'b00010);
    chk("stall accept count1", cnt_of(1), 32'd1);
    chk_flags("stall accept", 5'b0, 5'b0, 5'b0);

    // Same, with payload changed on stall cycle 3.
    step(1'b1, 1'b1, 5'b0, 5'b0);
    dat[1] = 16'hABCD;
    repeat (2) step(1'b0, 1'b1, 5'b00010, 5'b00000);
    chk_flags("chg cyc2", 5'b0, 5'b0, 5'b0);
    dat[1] = 16'hABCE;
    step(1'b0, 1'b1, 5'b00010, 5'b00000);
    chk_flags("chg cyc3", 5'b0, 5'b00010, 5'b0);
    repeat (2) step(1'b0, 1'b1, 5'b00010, 5'b00000);
    step(1'b0, 1'b1, 5'b00010, 5'b00010);
    chk("chg accept count1", cnt_of(1), 32'd1);
    chk_flags("chg accept", 5'b0, 5'b00010, 5'b0);

    // Watchdog on ch3: 8 stall cycles flag timeout.
    step(1'b1, 1'b1, 5'b0, 5'b0);
    dat[3] = 16'h0333;
    repeat (7) step(1'b0, 1'b1, 5'b01000, 5'b00000);
    chk_flags("wd cyc7", 5'b0, 5'b0, 5'b0);
    step(1'b0, 1'b1, 5'b01000, 5'b00000);
    chk_flags("wd cyc8", 5'b0, 5'b0, 5'b01000);
    repeat (3) step(1'b0, 1'b1, 5'b01000, 5'b00000);
    step(1'b0, 1'b1, 5'b01000, 5'b01000);
    chk("wd late accept count3", cnt_of(3), 32'd1);
    chk_flags("wd sticky", 5'b0, 5'b0, 5'b01000);

    // Acceptance exactly on cycle 8 beats the timeout.
    step(1'b1, 1'b1, 5'b0, 5'b0);
    repeat (7) step(1'b0, 1'b1, 5'b01000, 5'b00000);
    step(1'b0, 1'b1, 5'b01000, 5'b01000);
    chk("wd edge count3", cnt_of(3), 32'd1);
    chk_flags("wd edge", 5'b0, 5'b0, 5'b0);

    // Reset mid-stall on ch4 with a flag and a count set.
    step(1'b1, 1'b1, 5'b0, 5'b0);
    dat[4] = 16'h0444;
    step(1'b0, 1'b1, 5'b10000, 5'b10000);
    step(1'b0, 1'b1, 5'b10000, 5'b00000);
    step(1'b0, 1'b1, 5'b00000, 5'b00000);
    chk_flags("pre-reset", 5'b10000, 5'b0, 5'b0);
    chk("pre-reset count4", cnt_of(4), 32'd1);
    repeat (3) step(1'b0, 1'b1, 5'b10000, 5'b00000);
    step(1'b1, 1'b1, 5'b10000, 5'b00000);
    chk_flags("mid-stall reset", 5'b0, 5'b0, 5'b0);
    chk("mid-stall reset count4", cnt_of(4), 32'd0);

    // Disable during a stall, drop valid, re-enable.
    step(1'b0, 1'b1, 5'b00000, 5'b00000);
    step(1'b0, 1'b1, 5'b10000, 5'b10000);
    repeat (2) step(1'b0, 1'b1, 5'b10000, 5'b00000);
    step(1'b0, 1'b0, 5'b10000, 5'b00000);
    step(1'b0, 1'b0, 5'b00000, 5'b00000);
    step(1'b0, 1'b0, 5'b10000, 5'b10000);
    chk_flags("disabled drop", 5'b0, 5'b0, 5'b0);
    chk("disabled count4", cnt_of(4), 32'd1);
    step(1'b0, 1'b1, 5'b10000, 5'b10000);
    chk("reenable count4", cnt_of(4), 32'd2);
    step(1'b0, 1'b1, 5'b00000, 5'b00000);
    chk_flags("reenable", 5'b0, 5'b0, 5'b0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      dat = vecs[i].d;
      step(vecs[i].rst, vecs[i].en, vecs[i].v, vecs[i].rdy);
      chk_flags($sformatf("vec%0d", i), vecs[i].e_drop, vecs[i].e_data, vecs[i].e_to);
      chk($sformatf("vec%0d count%0d", i, vecs[i].ch), cnt_of(vecs[i].ch), vecs[i].cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
